// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        CH_INSTR,
        CH_DATA
    } chan_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Wait counter must hold WAIT_CYCLES but never collapse to zero bits.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - per-access wait-state down counter with zero flag
module mem_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = cnt_width(WAIT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WAIT_CYCLES);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one single-ported memory with wait states and CPU stall
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N           = 32,
    parameter int AW          = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int PRIORITY    = PRIO_FIXED
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [N-1:0]  i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [N-1:0]  d_wdata,
    output logic [N-1:0]  d_rdata,
    output logic          d_ready,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [N-1:0]  m_wdata,
    input  logic [N-1:0]  m_rdata,
    output logic          stall
);

    state_t state, state_nxt;
    chan_t  winner, ptr, pick;
    logic   we_q;
    logic   any_req, tie, grant, t_zero;

    assign any_req = i_req | d_req;
    assign tie     = i_req & d_req;
    assign grant   = (state == IDLE) && any_req;

    always_comb begin
        pick = CH_INSTR;
        if ((PRIORITY == PRIO_RR) && tie) begin
            pick = ptr;
        end else if (d_req) begin
            pick = CH_DATA;
        end
    end

    mem_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (grant),
        .dec  (state == ACCESS),
        .zero (t_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (t_zero) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner  <= CH_INSTR;
            ptr     <= CH_DATA;
            we_q    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (grant) begin
                winner  <= pick;
                we_q    <= (pick == CH_DATA) && d_we;
                m_addr  <= (pick == CH_DATA) ? d_addr : i_addr;
                m_wdata <= (pick == CH_DATA) ? d_wdata : '0;
                // Round-robin pointer only moves when both channels contended.
                if ((PRIORITY == PRIO_RR) && tie) begin
                    ptr <= (pick == CH_DATA) ? CH_INSTR : CH_DATA;
                end
            end
            if ((state == ACCESS) && t_zero && !we_q) begin
                if (winner == CH_DATA) begin
                    d_rdata <= m_rdata;
                end else begin
                    i_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_en    = (state == ACCESS);
    assign m_we    = m_en && we_q;
    assign i_ready = (state == DONE) && (winner == CH_INSTR);
    assign d_ready = (state == DONE) && (winner == CH_DATA);
    assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter across three parameter sets
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        if (k == 16) return 32'h8C02_0004;
        if (k == 32) return 32'h0000_002A;
        return 32'h1000_0000 + 32'(k) * 32'd257;
    endfunction

    // cfg[0]: WAIT=2 fixed priority; cfg[1]: WAIT=2 round robin; cfg[2]: WAIT=0 round robin
    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W = (g == 2) ? 0 : 2;
        localparam int P = (g == 0) ? 0 : 1;

        logic        rst_n, i_req, d_req, d_we;
        logic        i_ready, d_ready, m_en, m_we, stall;
        logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [31:0] mem [64];
        logic [31:0] ref_mem [64];
        bit          mem_ok = 1'b0;
        bit          ref_ok = 1'b0;

        mem_arbiter #(
            .N(32), .AW(32), .WAIT_CYCLES(W), .PRIORITY(P)
        ) dut (
            .clk    (clk),
            .reset  (rst_n),
            .i_req  (i_req),
            .i_addr (i_addr),
            .i_rdata(i_rdata),
            .i_ready(i_ready),
            .d_req  (d_req),
            .d_we   (d_we),
            .d_addr (d_addr),
            .d_wdata(d_wdata),
            .d_rdata(d_rdata),
            .d_ready(d_ready),
            .m_en   (m_en),
            .m_we   (m_we),
            .m_addr (m_addr),
            .m_wdata(m_wdata),
            .m_rdata(m_rdata),
            .stall  (stall)
        );

        always @(posedge clk) begin
            if (!mem_ok) begin
                for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
                mem_ok <= 1'b1;
            end else if (m_en && m_we) begin
                mem[m_addr[7:2]] <= m_wdata;
            end
        end
        assign m_rdata = mem[m_addr[7:2]];

        // Transaction-level model: a grant at cycle t0 owns the memory for
        // cycles t0+1..t0+W+1 and completes with a ready at t0+W+2.
        bit          busy, win_d, win_we, ptr_d;
        int          t0;
        logic [31:0] win_addr, win_wdata, exp_i, exp_d;
        bit          p_ireq, p_irdy, p_dreq, p_drdy;

        always @(negedge clk) begin
            bit acc, dn, e_ir, e_dr;
            int rel;
            if (!ref_ok) begin
                for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
                ref_ok = 1'b1;
            end
            if (!rst_n) begin
                busy = 0; ptr_d = 1; exp_i = '0; exp_d = '0;
                p_ireq = 0; p_irdy = 0; p_dreq = 0; p_drdy = 0;
                chk("rst_m_en", m_en, 0);
                chk("rst_m_we", m_we, 0);
                chk("rst_i_ready", i_ready, 0);
                chk("rst_d_ready", d_ready, 0);
                chk("rst_m_addr", m_addr, 0);
                chk("rst_m_wdata", m_wdata, 0);
                chk("rst_i_rdata", i_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
            end else begin
                acc = 0; dn = 0;
                if (busy) begin
                    rel = cyc - t0;
                    acc = (rel >= 1) && (rel <= W + 1);
                    dn  = (rel == W + 2);
                end
                e_ir = dn && !win_d;
                e_dr = dn && win_d;
                if (dn && !win_we) begin
                    if (win_d) exp_d = ref_mem[win_addr[7:2]];
                    else       exp_i = ref_mem[win_addr[7:2]];
                end
                if (dn && win_we) ref_mem[win_addr[7:2]] = win_wdata;
                chk("m_en", m_en, acc);
                chk("m_we", m_we, acc && win_we);
                chk("i_ready", i_ready, e_ir);
                chk("d_ready", d_ready, e_dr);
                chk("stall", stall, (i_req && !e_ir) || (d_req && !e_dr));
                chk("i_rdata", i_rdata, exp_i);
                chk("d_rdata", d_rdata, exp_d);
                if (acc) chk("m_addr", m_addr, win_addr);
                if (acc && win_we) chk("m_wdata", m_wdata, win_wdata);
                if (p_ireq && !p_irdy) chk("i_req_held", i_req, 1);
                if (p_dreq && !p_drdy) chk("d_req_held", d_req, 1);
                p_ireq = i_req; p_irdy = i_ready; p_dreq = d_req; p_drdy = d_ready;
                if (dn) begin
                    busy = 0;
                end else if (!busy && (i_req || d_req)) begin
                    if (P == 1 && i_req && d_req) begin
                        win_d = ptr_d;
                        ptr_d = !ptr_d;
                    end else begin
                        win_d = d_req;
                    end
                    win_we    = win_d && d_we;
                    win_addr  = win_d ? d_addr : i_addr;
                    win_wdata = d_wdata;
                    busy      = 1;
                    t0        = cyc;
                end
            end
        end

        task automatic start();
            rst_n = 0; i_req = 0; d_req = 0; d_we = 0;
            i_addr = '0; d_addr = '0; d_wdata = '0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1;
        endtask

        task automatic rand_phase(input int n);
            bit ir, dr;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                ir = i_ready; dr = d_ready;
                @(posedge clk);
                #1;
                if (i_req && ir) i_req = 0;
                if (d_req && dr) d_req = 0;
                if (!i_req && $urandom_range(0, 2) == 0) begin
                    i_req  = 1;
                    i_addr = 32'($urandom_range(0, 63)) << 2;
                end
                if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req   = 1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = 32'($urandom_range(0, 63)) << 2;
                    d_wdata = $urandom;
                end
            end
            done_cnt++;
        endtask

        if (g == 0) begin : drv
            initial begin
                start();
                i_req = 1; i_addr = 32'h40;
                for (int k = 0; k <= 4; k++) begin
                    @(negedge clk);
                    chk("t1_m_en", m_en, (k >= 1) && (k <= 3));
                    chk("t1_i_ready", i_ready, k == 4);
                    chk("t1_stall", stall, k <= 3);
                    if (k == 4) chk("t1_i_rdata", i_rdata, 32'h8C02_0004);
                    @(posedge clk); #1;
                end
                i_req = 0;
                i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
                for (int k = 0; k <= 9; k++) begin
                    @(negedge clk);
                    chk("t2_d_ready", d_ready, k == 4);
                    chk("t2_i_ready", i_ready, k == 9);
                    if (k == 4) chk("t2_d_rdata", d_rdata, 32'h2A);
                    if (k == 5) chk("t2_idle_gap", m_en, 0);
                    if (k == 6) chk("t2_fetch_addr", m_addr, 32'h40);
                    if (k == 9) chk("t2_i_rdata", i_rdata, 32'h8C02_0004);
                    @(posedge clk); #1;
                    if (k == 4) d_req = 0;
                end
                i_req = 0;
                d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
                for (int k = 0; k <= 4; k++) begin
                    @(negedge clk);
                    chk("t4_m_we", m_we, (k >= 1) && (k <= 3));
                    if (k >= 1 && k <= 3) begin
                        chk("t4_m_addr", m_addr, 32'h10);
                        chk("t4_m_wdata", m_wdata, 32'hDEAD_BEEF);
                    end
                    chk("t4_d_ready", d_ready, k == 4);
                    if (k == 4) chk("t4_d_rdata", d_rdata, 32'h2A);
                    @(posedge clk); #1;
                end
                d_req = 0; d_we = 0;
                chk("t4_mem", mem[4], 32'hDEAD_BEEF);
                i_req = 1; i_addr = 32'h80;
                @(negedge clk);
                @(posedge clk); #1;
                @(negedge clk);
                @(posedge clk);
                #2 rst_n = 0; i_req = 0;
                #1;
                chk("t5_async_m_en", m_en, 0);
                chk("t5_async_i_rdata", i_rdata, 0);
                chk("t5_async_d_rdata", d_rdata, 0);
                chk("t5_async_m_addr", m_addr, 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("t5_no_ready", {i_ready, d_ready}, 0);
                end
                @(posedge clk);
                #1 rst_n = 1; i_req = 1; i_addr = 32'h40;
                for (int k = 0; k <= 4; k++) begin
                    @(negedge clk);
                    chk("t5_i_ready", i_ready, k == 4);
                    if (k == 4) chk("t5_i_rdata", i_rdata, 32'h8C02_0004);
                    @(posedge clk); #1;
                end
                i_req = 0;
                rand_phase(600);
            end
        end else if (g == 1) begin : drv
            initial begin
                int first;
                bit ir, dr;
                start();
                for (int r = 0; r < 3; r++) begin
                    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
                    first = -1;
                    for (int k = 0; k < 30; k++) begin
                        @(negedge clk);
                        ir = i_ready; dr = d_ready;
                        if (first < 0 && (ir || dr)) first = dr ? 1 : 0;
                        @(posedge clk); #1;
                        if (ir) i_req = 0;
                        if (dr) d_req = 0;
                        if (!i_req && !d_req) break;
                    end
                    chk("t3_first_grant", 32'(first), (r == 1) ? 32'd0 : 32'd1);
                    chk("t3_round_done", {i_req, d_req}, 0);
                    i_req = 0; d_req = 0;
                end
                rand_phase(600);
            end
        end else begin : drv
            initial begin
                start();
                i_req = 1; i_addr = 32'h40;
                for (int k = 0; k <= 8; k++) begin
                    @(negedge clk);
                    chk("t6_m_en", m_en, (k % 3) == 1);
                    chk("t6_i_ready", i_ready, (k % 3) == 2);
                    if ((k % 3) == 2) chk("t6_i_rdata", i_rdata, init_word(int'(i_addr[7:2])));
                    @(posedge clk); #1;
                    if ((k % 3) == 2) i_addr = i_addr + 32'd4;
                end
                i_req = 0;
                rand_phase(600);
            end
        end
    end

    initial begin
        for (int t = 0; t < 20000 && done_cnt < 3; t++) @(posedge clk);
        if (done_cnt < 3) chk("run_timeout", 32'(done_cnt), 32'd3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
